// File: rtl/axi_lite_timer_pkg.sv
// timer_defs: register offsets, response codes, CTRL bits and FSM states shared by the timer block
package timer_defs;
    localparam logic [27:0] TIMER_MTIME    = 28'h00;
    localparam logic [27:0] TIMER_MTIMECMP = 28'h08;
    localparam logic [27:0] TIMER_CTRL     = 28'h10;
    localparam logic [27:0] TIMER_PRESC    = 28'h18;
    localparam logic [2:0] RESP_OKAY   = 3'b000;
    localparam logic [2:0] RESP_SLVERR = 3'b010;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;
endpackage

// File: rtl/axi_lite_timer_counter.sv
// timer_counter: prescaled 64-bit MTIME, compare register, control bits and registered level interrupt
module timer_counter
    import timer_defs::*;
#(
    parameter int PRESC_W = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               we_mtime,
    input  logic               we_cmp,
    input  logic               we_ctrl,
    input  logic               we_presc,
    input  logic [63:0]        mask,
    input  logic [63:0]        wdata,
    output logic [63:0]        mtime,
    output logic [63:0]        mtimecmp,
    output logic [1:0]         ctrl,
    output logic [PRESC_W-1:0] presc,
    output logic               irq
);
    logic [PRESC_W-1:0] pcnt;
    logic               tick;

    assign tick = ctrl[CTRL_EN] && pcnt == presc;

    // a software MTIME write takes priority over a same-cycle tick
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            mtime    <= '0;
            mtimecmp <= '1;
            ctrl     <= '0;
            presc    <= '0;
            pcnt     <= '0;
            irq      <= 1'b0;
        end else begin
            mtime    <= we_mtime ? (mtime & ~mask) | (wdata & mask) : tick ? mtime + 64'd1 : mtime;
            mtimecmp <= we_cmp ? (mtimecmp & ~mask) | (wdata & mask) : mtimecmp;
            ctrl     <= we_ctrl ? (ctrl & ~mask[1:0]) | (wdata[1:0] & mask[1:0]) : ctrl;
            presc    <= we_presc ? (presc & ~mask[PRESC_W-1:0]) | (wdata[PRESC_W-1:0] & mask[PRESC_W-1:0]) : presc;
            pcnt     <= we_presc || tick ? '0 : ctrl[CTRL_EN] ? pcnt + PRESC_W'(1) : pcnt;
            irq      <= ctrl[CTRL_IRQ_EN] && mtime >= mtimecmp;
        end
    end
endmodule

// File: rtl/axi_lite_timer.sv
// axi_lite_timer: AXI4-Lite front end with independent write/read FSMs around timer_counter.
// All return-channel outputs are zero unless this block is actively responding.
module axi_lite_timer
    import timer_defs::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int PRESC_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              AWVALID,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [2:0]        AWPROT,
    output logic              AWREADY,
    input  logic              WVALID,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [3:0]        WSTRB,
    output logic              WREADY,
    input  logic              BREADY,
    output logic              BVALID,
    output logic [2:0]        BRESP,
    input  logic              ARVALID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [2:0]        ARPROT,
    output logic              ARREADY,
    output logic              RVALID,
    output logic [DATA_W-1:0] RDATA,
    output logic [2:0]        RRESP,
    input  logic              RREADY,
    output logic              TimerIrq
);
    logic [DATA_W-1:0]  mask, rd_val, rdata;
    logic [63:0]        mtime, mtimecmp;
    logic [1:0]         ctrl;
    logic [PRESC_W-1:0] presc;
    logic [2:0]         bresp, rresp, rd_resp;
    logic [3:0]         wsel, rsel;
    logic               aw_hs, ar_hs, prot_unused;
    wstate_t            wstate, wstate_n;
    rstate_t            rstate, rstate_n;

    assign prot_unused = ^{AWPROT, ARPROT};

    assign wsel = {AWADDR == ADDR_W'(TIMER_PRESC), AWADDR == ADDR_W'(TIMER_CTRL),
                   AWADDR == ADDR_W'(TIMER_MTIMECMP), AWADDR == ADDR_W'(TIMER_MTIME)};
    assign rsel = {ARADDR == ADDR_W'(TIMER_PRESC), ARADDR == ADDR_W'(TIMER_CTRL),
                   ARADDR == ADDR_W'(TIMER_MTIMECMP), ARADDR == ADDR_W'(TIMER_MTIME)};

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign mask[i*(DATA_W/4) +: DATA_W/4] = {(DATA_W/4){WSTRB[i]}};
    end

    assign rd_val  = rsel[0] ? mtime : rsel[1] ? mtimecmp : rsel[2] ? DATA_W'(ctrl) :
                     rsel[3] ? DATA_W'(presc) : '0;
    assign rd_resp = |rsel ? RESP_OKAY : RESP_SLVERR;

    always_comb begin
        aw_hs    = Rst && wstate == W_IDLE && AWVALID && WVALID;
        ar_hs    = Rst && rstate == R_IDLE && ARVALID;
        AWREADY  = aw_hs;
        WREADY   = aw_hs;
        ARREADY  = ar_hs;
        BVALID   = wstate == W_RESP;
        BRESP    = BVALID ? bresp : RESP_OKAY;
        RVALID   = rstate == R_DATA;
        RDATA    = RVALID ? rdata : '0;
        RRESP    = RVALID ? rresp : RESP_OKAY;
        wstate_n = aw_hs ? W_RESP : BVALID && BREADY ? W_IDLE : wstate;
        rstate_n = ar_hs ? R_DATA : RVALID && RREADY ? R_IDLE : rstate;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
            bresp  <= RESP_OKAY;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else begin
            wstate <= wstate_n;
            rstate <= rstate_n;
            bresp  <= aw_hs ? (|wsel ? RESP_OKAY : RESP_SLVERR) : bresp;
            rresp  <= ar_hs ? rd_resp : rresp;
            rdata  <= ar_hs ? rd_val : rdata;
        end
    end

    timer_counter #(.PRESC_W(PRESC_W)) u_counter (
        .Clk      (Clk),
        .Rst      (Rst),
        .we_mtime (aw_hs && wsel[0]),
        .we_cmp   (aw_hs && wsel[1]),
        .we_ctrl  (aw_hs && wsel[2]),
        .we_presc (aw_hs && wsel[3]),
        .mask     (mask),
        .wdata    (WDATA),
        .mtime    (mtime),
        .mtimecmp (mtimecmp),
        .ctrl     (ctrl),
        .presc    (presc),
        .irq      (TimerIrq)
    );
endmodule
